mux_nto1_scan: RTL and testbench
================================

Name: mux_nto1_scan

Overview:
- Parametrised N-channel, W-bit registered multiplexer, built as the successor to the fixed 2:1 and 4:1 muxes.
- Two modes:
  - Manual: the channel is chosen by `sel`.
  - Auto-scan: an internal pointer steps round-robin through all channels, dwelling a programmable number of cycles on each.
- Output is registered, with valid, channel tag and wrap flag. Used as the input-selection stage in front of display and measurement blocks.

Parameters:
- WIDTH, 8, data bits per channel.
- NCH, 4, number of channels (>=2; need not be a power of 2).
- DWELL, 4, cycles spent on each channel in scan mode (>=1).
- SELW, $clog2(NCH), select/tag width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_bus  input  NCH*WIDTH  packed channels; channel k = in_bus[k*WIDTH +: WIDTH].
- sel  input  SELW  manual channel select.
- mode  input  1  0 = manual, 1 = scan.
- en  input  1  block enable.
- hold  input  1  freeze all registers.
- out  output  WIDTH  registered selected data.
- out_sel  output  SELW  index of the channel that produced out.
- out_valid  output  1  out holds valid channel data.
- wrap  output  1  one-cycle pulse on the last dwell sample of channel NCH-1.

Behaviour:
- Single clock domain. Everything is evaluated on the rising edge of clk. Priority: rst > !en > hold > normal operation.
- Reset (rst=1 at an edge):
  - out=0, out_sel=0, out_valid=0, wrap=0.
  - state=IDLE, ptr=0, cnt=0.
  - Reset mid-scan abandons the scan immediately.
- States: IDLE, MANUAL, SCAN.
  - Next state is IDLE if en=0, MANUAL if en=1 & mode=0, SCAN if en=1 & mode=1.
  - hold=1 keeps the current state.
- IDLE (en=0): out and out_sel keep their last value; out_valid<=0, wrap<=0, ptr<=0, cnt<=0.
- hold=1 (en=1):
  - out, out_sel, out_valid, state, ptr and cnt all keep their values; wrap<=0.
  - The dwell count does not advance.
- MANUAL (en=1, mode=0, hold=0):
  - Latency 1: values at edge t+1 reflect in_bus and sel sampled at edge t.
  - If sel<NCH: out<=channel[sel], out_sel<=sel, out_valid<=1.
  - If sel>=NCH (possible when NCH is not a power of 2): out<=0, out_sel<=sel, out_valid<=0.
  - Always: wrap<=0, ptr<=0, cnt<=0.
- SCAN (en=1, mode=1, hold=0):
  - Let p = ptr and c = cnt if the state was already SCAN; otherwise p=0 and c=0 (every entry restarts at channel 0).
  - Each edge: out<=channel[p] (live data, re-sampled every cycle), out_sel<=p, out_valid<=1.
  - If c==DWELL-1:
    - cnt<=0.
    - ptr<=(p==NCH-1) ? 0 : p+1.
    - wrap<=(p==NCH-1).
  - Otherwise: cnt<=c+1, ptr<=p, wrap<=0.
  - Result: each channel appears on out_sel for exactly DWELL consecutive edges. The entry edge counts as the first of them.
  - With DWELL=1 the channel changes every cycle and wrap is asserted once every NCH cycles.
- Mode switches take effect at the next edge with no idle cycle.
  - SCAN→MANUAL: the next out is channel[sel].
  - MANUAL→SCAN: the next out is channel 0.
- cnt width is $clog2(DWELL), minimum 1. The pointer wraps explicitly at NCH-1, never via natural overflow.

Test Plan:
- Reset with rst=1 for 2 cycles, all inputs toggling → out=0x00, out_sel=0, out_valid=0, wrap=0 throughout; stays so after release while en=0.
- Manual mode, WIDTH=8, NCH=4, in_bus={0xDD,0xCC,0xBB,0xAA} (ch0=0xAA), en=1, sel=2 → one edge later out=0xCC, out_sel=2, out_valid=1. Change sel to 0 → next edge out=0xAA.
- Scan mode, DWELL=4, constant in_bus as above → out_sel sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0,… with matching out values. wrap=1 only on the 16th edge (4th sample of ch3), then every 16 edges.
- hold during scan: assert hold for 5 cycles after the 2nd ch1 sample → out/out_sel frozen at ch1 and wrap=0. After release, ch1 gets exactly 2 more samples, then ch2.
- NCH=3, DWELL=1, manual sel=3 → out=0, out_valid=0. Then mode=1 → out_sel 0,1,2,0,… with wrap pulsing every 3rd edge.
- Reset mid-scan (rst at ch2), then en=1, mode=1 → restarts at ch0 with a full DWELL count. Toggle en=0 for 1 cycle mid-scan → out_valid=0 for that cycle, then the scan restarts at ch0.

Source files
------------

// File: rtl/mux_nto1_scan.sv
// mux_nto1_scan: registered N:1 mux with manual select and round-robin auto-scan
module mux_nto1_scan #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int DWELL = 4,
    parameter int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] in_bus,
    input  logic [SELW-1:0]      sel,
    input  logic                 mode,
    input  logic                 en,
    input  logic                 hold,
    output logic [WIDTH-1:0]     out,
    output logic [SELW-1:0]      out_sel,
    output logic                 out_valid,
    output logic                 wrap
);
    localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;
    localparam logic [1:0] IDLE = 2'd0, MANUAL = 2'd1, SCAN = 2'd2;

    logic [1:0]       state;
    logic [SELW-1:0]  ptr, p;
    logic [CW-1:0]    cnt, c;
    logic [WIDTH-1:0] man_d, scan_d;
    logic             sel_ok, last, p_last;

    // entering scan from any other state restarts at channel 0 with a fresh dwell
    assign p      = state == SCAN ? ptr : '0;
    assign c      = state == SCAN ? cnt : '0;
    assign last   = c == CW'(DWELL - 1);
    assign p_last = p == SELW'(NCH - 1);

    always_comb begin
        man_d  = '0;
        scan_d = '0;
        sel_ok = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (sel == SELW'(k)) begin
                man_d  = in_bus[k*WIDTH +: WIDTH];
                sel_ok = 1'b1;
            end
            if (p == SELW'(k)) scan_d = in_bus[k*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out       <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
            ptr       <= '0;
            cnt       <= '0;
        end else if (!en) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
            ptr       <= '0;
            cnt       <= '0;
        end else if (hold) begin
            wrap <= 1'b0;
        end else if (!mode) begin
            state     <= MANUAL;
            out       <= man_d;
            out_sel   <= sel;
            out_valid <= sel_ok;
            wrap      <= 1'b0;
            ptr       <= '0;
            cnt       <= '0;
        end else begin
            state     <= SCAN;
            out       <= scan_d;
            out_sel   <= p;
            out_valid <= 1'b1;
            cnt       <= last ? '0 : c + CW'(1);
            ptr       <= !last ? p : p_last ? '0 : p + SELW'(1);
            wrap      <= last && p_last;
        end
    end
endmodule

// File: tb/tb_mux_nto1_scan.sv
// tb_mux_nto1_scan: directed vector bench for the 4-channel/dwell-4 and 3-channel/dwell-1 variants
module tb_mux_nto1_scan;
    typedef struct {
        logic       rst, en, mode, hold;
        logic [1:0] sel;
        logic [7:0] eo;
        logic [1:0] es;
        logic       ev, ew;
    } vec_t;

    logic        clk = 0;
    logic        rst, en, mode, hold;
    logic [1:0]  sel;
    logic [31:0] in_bus;
    logic [7:0]  out;
    logic [1:0]  out_sel;
    logic        out_valid, wrap;

    logic        rst1, en1, mode1, hold1;
    logic [1:0]  sel1;
    logic [23:0] in_bus1;
    logic [7:0]  out1;
    logic [1:0]  out_sel1;
    logic        out_valid1, wrap1;

    int errors = 0, checks = 0;
    vec_t tv[$];
    logic [7:0] chv [4];
    logic [7:0] chv1 [3];

    mux_nto1_scan #(.WIDTH(8), .NCH(4), .DWELL(4)) u0 (
        .clk(clk), .rst(rst), .in_bus(in_bus), .sel(sel), .mode(mode), .en(en), .hold(hold),
        .out(out), .out_sel(out_sel), .out_valid(out_valid), .wrap(wrap)
    );

    mux_nto1_scan #(.WIDTH(8), .NCH(3), .DWELL(1)) u1 (
        .clk(clk), .rst(rst1), .in_bus(in_bus1), .sel(sel1), .mode(mode1), .en(en1), .hold(hold1),
        .out(out1), .out_sel(out_sel1), .out_valid(out_valid1), .wrap(wrap1)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic e, logic m, logic h, logic [1:0] s,
                                logic [7:0] eo, logic [1:0] es, logic ev, logic ew);
        vec_t v;
        v.rst = r; v.en = e; v.mode = m; v.hold = h; v.sel = s;
        v.eo = eo; v.es = es; v.ev = ev; v.ew = ew;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic m, input logic h, input logic [1:0] s);
        rst = r; en = e; mode = m; hold = h; sel = s;
        @(posedge clk);
        #1;
    endtask

    task automatic chk0(input string tag, input logic [7:0] eo, input logic [1:0] es,
                        input logic ev, input logic ew);
        check({tag, ".out"}, 32'(out), 32'(eo));
        check({tag, ".out_sel"}, 32'(out_sel), 32'(es));
        check({tag, ".valid"}, 32'(out_valid), 32'(ev));
        check({tag, ".wrap"}, 32'(wrap), 32'(ew));
    endtask

    task automatic step0(input string tag, input logic r, input logic e, input logic m, input logic h,
                         input logic [1:0] s, input logic [7:0] eo, input logic [1:0] es,
                         input logic ev, input logic ew);
        drive(r, e, m, h, s);
        chk0(tag, eo, es, ev, ew);
    endtask

    task automatic step1(input string tag, input logic r, input logic e, input logic m,
                         input logic [1:0] s, input logic [7:0] eo, input logic [1:0] es,
                         input logic ev, input logic ew);
        rst1 = r; en1 = e; mode1 = m; sel1 = s;
        @(posedge clk);
        #1;
        check({tag, ".out"}, 32'(out1), 32'(eo));
        check({tag, ".out_sel"}, 32'(out_sel1), 32'(es));
        check({tag, ".valid"}, 32'(out_valid1), 32'(ev));
        check({tag, ".wrap"}, 32'(wrap1), 32'(ew));
    endtask

    initial begin
        chv[0] = 8'hAA; chv[1] = 8'hBB; chv[2] = 8'hCC; chv[3] = 8'hDD;
        chv1[0] = 8'h11; chv1[1] = 8'h22; chv1[2] = 8'h33;
        in_bus = 32'hDDCCBBAA;
        in_bus1 = 24'h332211;
        rst = 1; en = 0; mode = 0; hold = 0; sel = 0;
        rst1 = 1; en1 = 0; mode1 = 0; hold1 = 0; sel1 = 0;

        // reset with inputs toggling, then idle after release
        tv.push_back(mk(1, 1, 1, 1, 3, 8'h00, 0, 0, 0));
        tv.push_back(mk(1, 1, 0, 0, 2, 8'h00, 0, 0, 0));
        tv.push_back(mk(0, 0, 1, 0, 1, 8'h00, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 1, 2, 8'h00, 0, 0, 0));
        // manual selection
        tv.push_back(mk(0, 1, 0, 0, 2, 8'hCC, 2, 1, 0));
        tv.push_back(mk(0, 1, 0, 0, 0, 8'hAA, 0, 1, 0));
        tv.push_back(mk(0, 1, 0, 0, 3, 8'hDD, 3, 1, 0));
        // full scan pass plus the start of the next; wrap on the 16th edge
        for (int i = 0; i < 20; i++)
            tv.push_back(mk(0, 1, 1, 0, 2, chv[(i/4)%4], 2'((i/4)%4), 1, i == 15));
        // scan -> manual -> scan, no idle cycle
        tv.push_back(mk(0, 1, 0, 0, 1, 8'hBB, 1, 1, 0));
        tv.push_back(mk(0, 1, 1, 0, 1, 8'hAA, 0, 1, 0));
        for (int i = 0; i < 3; i++) tv.push_back(mk(0, 1, 1, 0, 1, 8'hAA, 0, 1, 0));
        tv.push_back(mk(0, 1, 1, 0, 1, 8'hBB, 1, 1, 0));

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].rst, tv[i].en, tv[i].mode, tv[i].hold, tv[i].sel);
            chk0($sformatf("vec%0d", i), tv[i].eo, tv[i].es, tv[i].ev, tv[i].ew);
        end

        // en low for one cycle: out/out_sel keep, valid drops, then fresh scan with hold on ch1
        step0("en_off", 0, 0, 1, 0, 0, 8'hBB, 1, 0, 0);
        for (int i = 0; i < 6; i++)
            step0($sformatf("pre_hold%0d", i), 0, 1, 1, 0, 0, chv[i/4], 2'(i/4), 1, 0);
        for (int i = 0; i < 5; i++)
            step0($sformatf("hold%0d", i), 0, 1, 1, 1, 0, 8'hBB, 1, 1, 0);
        step0("post_hold0", 0, 1, 1, 0, 0, 8'hBB, 1, 1, 0);
        step0("post_hold1", 0, 1, 1, 0, 0, 8'hBB, 1, 1, 0);
        step0("post_hold2", 0, 1, 1, 0, 0, 8'hCC, 2, 1, 0);

        // reset mid-scan at ch2, then restart with a full dwell on ch0
        step0("rst_mid", 1, 1, 1, 0, 0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            step0($sformatf("after_rst%0d", i), 0, 1, 1, 0, 0, chv[i/4], 2'(i/4), 1, 0);

        // en toggle mid-scan at ch1
        step0("en_toggle", 0, 0, 1, 0, 0, 8'hBB, 1, 0, 0);
        for (int i = 0; i < 5; i++)
            step0($sformatf("after_en%0d", i), 0, 1, 1, 0, 0, chv[i/4], 2'(i/4), 1, 0);

        // live data in manual mode
        in_bus[23:16] = 8'h5A;
        step0("live", 0, 1, 0, 0, 2, 8'h5A, 2, 1, 0);
        in_bus = 32'hDDCCBBAA;

        // NCH=3, DWELL=1: out-of-range select, then per-cycle scan with wrap every 3rd edge
        step1("n3_rst", 1, 1, 0, 3, 8'h00, 0, 0, 0);
        step1("n3_sel3", 0, 1, 0, 3, 8'h00, 3, 0, 0);
        step1("n3_sel1", 0, 1, 0, 1, 8'h22, 1, 1, 0);
        for (int i = 0; i < 7; i++)
            step1($sformatf("n3_scan%0d", i), 0, 1, 1, 0, chv1[i%3], 2'(i%3), 1, (i%3) == 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
